// File: rtl/up_mod_counter.sv
// Modulo-MODULUS up counter with parallel load, cascade carry, sticky wrap flag and load-range error.
// Latency: count/ovf/load_err update one edge after their inputs; carry_out is zero-latency; no backpressure (en gates counting).
module up_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count_out,
  output logic             carry_out,
  output logic             ovf,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic             at_last;
  logic             wrap;
  logic             load_in_range;
  logic [WIDTH-1:0] count_inc;

  assign at_last   = (count_out == LAST);
  assign carry_out = en && at_last;
  assign wrap      = en && !load && at_last;
  assign count_inc = at_last ? '0 : count_out + WIDTH'(1);

  // A full binary range accepts every load_val; avoid a constant-true compare there.
  generate
    if (MODULUS == (2 ** WIDTH)) begin : g_full_range
      assign load_in_range = 1'b1;
    end else begin : g_partial_range
      assign load_in_range = (load_val <= LAST);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      count_out <= '0;
      ovf       <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_err <= load && !load_in_range;

      if (load) begin
        count_out <= load_in_range ? load_val : '0;
      end else if (en) begin
        count_out <= count_inc;
      end

      // A wrap on the same edge as clr_ovf keeps the flag set.
      if (wrap) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_up_mod_counter.sv
// Scoreboarded directed bench for up_mod_counter, covering the default and a MODULUS=10 instance.
module tb_up_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, load, clr_ovf;
  logic [3:0] load_val;

  logic [3:0] cnt16, cnt10;
  logic       car16, car10, ovf16, ovf10, ler16, ler10;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         sel;   // 0: default DUT, 1: MODULUS=10 DUT, 2: no check
    logic [3:0] cnt;
    logic       carry;
    logic       ovf;
    logic       lerr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  up_mod_counter u16 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count_out(cnt16), .carry_out(car16), .ovf(ovf16), .load_err(ler16)
  );

  up_mod_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count_out(cnt10), .carry_out(car10), .ovf(ovf10), .load_err(ler10)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected while they are applied.
  task automatic vec(input int s, input logic r, input logic e, input logic l,
                     input logic [3:0] lv, input logic c,
                     input logic [3:0] ec, input logic ecar, input logic eov, input logic ele);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; en = e; load = l; load_val = lv; clr_ovf = c;
    x.sel = s; x.cnt = ec; x.carry = ecar; x.ovf = eov; x.lerr = ele;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      if (x.sel == 0) begin
        check("m16_count", cnt16, x.cnt);
        check("m16_carry", {3'b0, car16}, {3'b0, x.carry});
        check("m16_ovf",   {3'b0, ovf16}, {3'b0, x.ovf});
        check("m16_lerr",  {3'b0, ler16}, {3'b0, x.lerr});
      end else if (x.sel == 1) begin
        check("m10_count", cnt10, x.cnt);
        check("m10_carry", {3'b0, car10}, {3'b0, x.carry});
        check("m10_ovf",   {3'b0, ovf10}, {3'b0, x.ovf});
        check("m10_lerr",  {3'b0, ler10}, {3'b0, x.lerr});
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
    @(posedge clk);

    // Default modulus: reset state, then full count with wrap.
    vec(0, 1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      vec(0, 0, 1, 0, 4'd0, 0,  4'(i % 16), (i == 15), (i == 16), 0);
    vec(0, 0, 0, 0, 4'd0, 0,  4'd1, 0, 1, 0);

    // Wrap coinciding with clr_ovf keeps ovf; a later clr_ovf alone clears it.
    vec(0, 0, 0, 1, 4'd14, 0, 4'd1,  0, 1, 0);
    vec(0, 0, 1, 0, 4'd0, 0,  4'd14, 0, 1, 0);
    vec(0, 0, 1, 0, 4'd0, 1,  4'd15, 1, 1, 0);
    vec(0, 0, 0, 0, 4'd0, 1,  4'd0,  0, 1, 0);
    vec(0, 0, 0, 0, 4'd0, 0,  4'd0,  0, 0, 0);

    // Load wins over en, then holds.
    vec(0, 0, 1, 1, 4'd7, 0,  4'd0, 0, 0, 0);
    vec(0, 0, 0, 0, 4'd0, 0,  4'd7, 0, 0, 0);
    vec(0, 0, 0, 0, 4'd0, 0,  4'd7, 0, 0, 0);
    vec(0, 0, 0, 0, 4'd0, 0,  4'd7, 0, 0, 0);

    // Carry with a coincident load: carry high, wrap suppressed, ovf untouched.
    vec(0, 0, 0, 1, 4'd15, 0, 4'd7,  0, 0, 0);
    vec(0, 0, 1, 1, 4'd3, 0,  4'd15, 1, 0, 0);
    vec(0, 0, 0, 1, 4'd15, 0, 4'd3,  0, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 0,  4'd15, 1, 0, 0);

    // Reset mid-count at 9 overrides load and clears ovf; counting resumes from 0.
    vec(0, 0, 0, 1, 4'd8, 0,  4'd0, 0, 1, 0);
    vec(0, 0, 1, 0, 4'd0, 0,  4'd8, 0, 1, 0);
    vec(0, 1, 1, 1, 4'd3, 0,  4'd9, 0, 1, 0);
    vec(0, 0, 1, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    vec(0, 0, 1, 0, 4'd0, 0,  4'd1, 0, 0, 0);
    vec(0, 0, 0, 0, 4'd0, 0,  4'd2, 0, 0, 0);

    // MODULUS=10: reset, count 0..9,0 with carry only at 9.
    vec(2, 1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    vec(1, 1, 0, 0, 4'd0, 0,  4'd0, 0, 0, 0);
    for (int i = 0; i < 11; i++)
      vec(1, 0, 1, 0, 4'd0, 0,  4'(i % 10), (i == 9), (i == 10), 0);
    vec(1, 0, 0, 0, 4'd0, 0,  4'd1, 0, 1, 0);

    // Out-of-range loads (12, then boundary 10) give 0 and a one-cycle load_err.
    vec(1, 0, 1, 1, 4'd12, 0, 4'd1, 0, 1, 0);
    vec(1, 0, 0, 0, 4'd0, 0,  4'd0, 0, 1, 1);
    vec(1, 0, 0, 0, 4'd0, 0,  4'd0, 0, 1, 0);
    vec(1, 0, 0, 1, 4'd9, 0,  4'd0, 0, 1, 0);
    vec(1, 0, 0, 1, 4'd10, 0, 4'd9, 0, 1, 0);
    vec(1, 0, 1, 0, 4'd0, 0,  4'd0, 0, 1, 1);
    vec(1, 0, 0, 0, 4'd0, 0,  4'd1, 0, 1, 0);

    // clr_ovf during a load still clears; the next wrap sets it again.
    vec(1, 0, 0, 1, 4'd9, 1,  4'd1, 0, 1, 0);
    vec(1, 0, 1, 0, 4'd0, 0,  4'd9, 1, 0, 0);
    vec(1, 0, 0, 0, 4'd0, 0,  4'd0, 0, 1, 0);

    @(posedge clk);
    #1;
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
